// File: rtl/addsub_pkg.sv
// Shared constants and FSM encoding for the byte-serial add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package addsub_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca_8.sv
// 8-bit ripple-carry adder shared by the byte-serial sequencer.
// Latency: combinational, zero cycles.
// Backpressure: none; pure datapath.
module rca_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic carry;

    // Ripple the carry from bit 0 upward.
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int k = 0; k < 8; k++) begin
            sum[k] = a[k] ^ b[k] ^ carry;
            carry  = (a[k] & b[k]) | (carry & (a[k] ^ b[k]));
        end
        cout = carry;
    end

endmodule

// File: rtl/addsub_seq_ctrl.sv
// Byte-serial N-byte add/subtract over one shared rca_8, LSB first; optional ADDSUB_OVF_EN adds signed overflow.
// Latency: done pulses NBYTES+1 cycles after the accepting edge; one request per NBYTES+1 cycles.
// Backpressure: start is only accepted in IDLE or DONE; starts during RUN are dropped, never queued.
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       sub,
    input  logic [BYTE_W*NBYTES-1:0]   a,
    input  logic [BYTE_W*NBYTES-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic [BYTE_W*NBYTES-1:0]   result,
    output logic                       cout
`ifdef ADDSUB_OVF_EN
    ,
    output logic                       ovf
`endif
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
    logic            sub_q, sub_d, c_q, c_d;
    logic [IW-1:0]   i_q, i_d;
    logic            busy_q, busy_d, done_q, done_d, cout_q, cout_d;
`ifdef ADDSUB_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    logic [BYTE_W-1:0] op_a, op_b, sum;
    logic              carry_out;

    // Select the current operand byte; B is inverted for two's-complement subtract.
    always_comb begin
        op_a = a_q[BYTE_W*i_q +: BYTE_W];
        op_b = b_q[BYTE_W*i_q +: BYTE_W] ^ {BYTE_W{sub_q}};
    end

    rca_8 u_rca (
        .a    (op_a),
        .b    (op_b),
        .cin  (c_q),
        .sum  (sum),
        .cout (carry_out)
    );

    // Next-state and next-output computation; DONE accepts start like IDLE for back-to-back ops.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        c_d      = c_q;
        i_d      = i_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef ADDSUB_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    sub_d    = sub;
                    c_d      = sub;
                    i_d      = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
`ifdef ADDSUB_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                result_d[BYTE_W*i_q +: BYTE_W] = sum;
                c_d = carry_out;
                if (i_q == LAST) begin
                    state_d = S_DONE;
                    cout_d  = carry_out;
`ifdef ADDSUB_OVF_EN
                    ovf_d   = (op_a[BYTE_W-1] == op_b[BYTE_W-1]) &&
                              (sum[BYTE_W-1] != op_a[BYTE_W-1]);
`endif
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // Single state/output register bank; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            c_q      <= 1'b0;
            i_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            c_q      <= c_d;
            i_q      <= i_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cout_q   <= cout_d;
`ifdef ADDSUB_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
`ifdef ADDSUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Directed-vector bench for addsub_seq_ctrl with NBYTES=4.
// Latency: expects done 4 negedges after the negedge following the start edge.
// Backpressure: exercises ignored start in RUN and back-to-back start in DONE.
module tb_addsub_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        cout;
`ifdef ADDSUB_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    addsub_seq_ctrl #(.NBYTES(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
`ifdef ADDSUB_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Drive a one-cycle start; returns at the negedge just after the accepting edge.
    task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic vsub);
        @(negedge clk);
        a = va; b = vb; sub = vsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done (bounded); lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_n);
        bit found;
        found  = 1'b0;
        lat    = -1;
        busy_n = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (busy) busy_n++;
            if (done) begin
                lat   = k;
                found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef ADDSUB_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, bn;
        issue(32'h000000FF, 32'h00000001, 1'b0);
        wait_done(lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++; if (bn !== 4) begin errors++; $display("FAIL add_busy_cycles got %0d want 4", bn); end
        checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL add_result got %h want 00000100", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL add_cout got %b want 0", cout); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", done); end
        checks++; if (result !== 32'h00000100) begin errors++; $display("FAIL add_result_hold got %h want 00000100", result); end
    endtask

    task automatic test_sub();
        int lat, bn;
        issue(32'd100, 32'd28, 1'b1);
        wait_done(lat, bn);
        checks++; if (result !== 32'd72) begin errors++; $display("FAIL sub_result got %h want 00000048", result); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL sub_cout got %b want 1", cout); end
    endtask

    task automatic test_wrap();
        int lat, bn;
        issue(32'hFFFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat, bn);
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL wrap_result got %h want 00000000", result); end
        checks++; if (cout !== 1'b1) begin errors++; $display("FAIL wrap_cout got %b want 1", cout); end
    endtask

`ifdef ADDSUB_OVF_EN
    task automatic test_ovf();
        int lat, bn;
        issue(32'h7FFFFFFF, 32'h00000001, 1'b0);
        wait_done(lat, bn);
        checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL ovf_add_result got %h want 80000000", result); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_add_flag got %b want 1", ovf); end
        issue(32'd200, 32'd55, 1'b1);
        wait_done(lat, bn);
        checks++; if (result !== 32'd145) begin errors++; $display("FAIL ovf_sub_result got %h want 00000091", result); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_sub_flag got %b want 0", ovf); end
    endtask
`endif

    task automatic test_start_ignored();
        int lat, bn;
        issue(32'd5, 32'd7, 1'b0);
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bn);
        checks++; if (lat !== 2) begin errors++; $display("FAIL ignored_latency got %0d want 2", lat); end
        checks++; if (result !== 32'd12) begin errors++; $display("FAIL ignored_result got %h want 0000000c", result); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_no_queue got busy %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int lat, bn;
        issue(32'h00010000, 32'h00000203, 1'b0);
        wait_done(lat, bn);
        checks++; if (result !== 32'h00010203) begin errors++; $display("FAIL b2b_first_result got %h want 00010203", result); end
        a = 32'd50; b = 32'd100; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy %b want 1", busy); end
        wait_done(lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d want 4", lat); end
        checks++; if (result !== 32'hFFFFFFCE) begin errors++; $display("FAIL b2b_sub_result got %h want ffffffce", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL b2b_sub_cout got %b want 0", cout); end
    endtask

    task automatic test_reset_abort();
        int lat, bn, dn;
        issue(32'h01010101, 32'h02020202, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b want 0", done); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL abort_result got %h want 00000000", result); end
        checks++; if (cout !== 1'b0) begin errors++; $display("FAIL abort_cout got %b want 0", cout); end
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dn++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dn); end
        issue(32'd3, 32'd4, 1'b0);
        wait_done(lat, bn);
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_recover_latency got %0d want 4", lat); end
        checks++; if (result !== 32'd7) begin errors++; $display("FAIL abort_recover_result got %h want 00000007", result); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_wrap();
`ifdef ADDSUB_OVF_EN
        test_ovf();
`endif
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq_ctrl.md
# addsub_seq_ctrl

Byte-serial multi-precision add/subtract sequencer that drives one shared `rca_8` ripple-carry adder. It performs an N-byte addition or subtraction one byte per clock, least-significant byte first, and chains the carry through a register. Subtraction uses two's complement: B is XORed with 8'hFF and the initial carry-in is 1. It sits between a requester issuing `start`/`sub` with wide operands and the single 8-bit adder datapath.

## Interface
- `NBYTES`, default 4: operand width in bytes. Legal range is 2..16; W = 8*NBYTES.
- `clk` input 1: single clock; every register updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request pulse; sampled only when the block is not busy.
- `sub` input 1: 0 = A+B, 1 = A−B. Latched with `start`.
- `a` input W: operand A. Latched with `start`.
- `b` input W: operand B. Latched with `start`.
- `busy` output 1: high while the block is in RUN.
- `done` output 1: one-cycle pulse that marks `result`/`cout`/`ovf` valid.
- `result` output W: sum or difference. Held until the next accepted `start`.
- `cout` output 1: final carry. For subtract, 1 means no borrow (A ≥ B unsigned).
- `ovf` output 1: signed overflow. Present only with `ADDSUB_OVF_EN`.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: `start`=1 does the following:
  - latches `a`, `b`, `sub`;
  - sets carry register c = `sub`;
  - sets byte index i = 0;
  - clears `result`;
  - moves to RUN.
- RUN, each cycle:
  - `rca_8` gets A = a[8i+7:8i], B = b[8i+7:8i] ^ {8{sub}}, Cin = c.
  - SUM is written into result[8i+7:8i] and Cout into c.
  - When i = NBYTES−1, the FSM moves to DONE; otherwise i increments.
- DONE: `done`=1 for exactly one cycle. `cout` = c. Next state is IDLE.
  - A `start` in the DONE cycle is accepted as if in IDLE (back-to-back operation).
- `start` during RUN is ignored, with no queuing.
- Arithmetic is modulo 2^W; no saturation.
- The index counter is ceil(log2(NBYTES)) bits wide and never wraps past NBYTES−1.
- Reset values:
  - state = IDLE;
  - `busy`, `done`, `cout`, `ovf` = 0;
  - `result` = 0;
  - c, i and operand registers = 0.
- Reset mid-operation aborts immediately. No `done` is produced for the aborted request.

## Timing
- Let edge 0 be the edge that samples `start`=1.
- `busy` is high from after edge 0 through edge NBYTES.
- Byte k is computed at edge k+1.
- `done` is high during the cycle after edge NBYTES, i.e. latency is NBYTES+1 cycles.
- For NBYTES=4: start at edge 0 gives `done` in cycle 5.
- Throughput: a new request every NBYTES+1 cycles.
- `result` bytes update progressively during RUN. They are valid only while `done`=1 and afterwards until the next accepted `start`.

## Configuration
- Macro: `ADDSUB_OVF_EN`.
- Defined:
  - `ovf` port exists.
  - At the final byte, the block registers ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted B when `sub`=1.
  - `ovf` updates in the DONE cycle and is held with `result`.
- Undefined:
  - no `ovf` port;
  - no overflow logic or registers.

## Structure
- Package `addsub_pkg`:
  - state encoding localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - BYTE_W=8.
- The only sub-module is the existing `rca_8`, instantiated once. The B inversion and the carry register live in this block.

## Test plan
All scenarios use NBYTES=4.
- Add 32'h000000FF + 32'h00000001 → `result` 32'h00000100, `cout` 0, `done` exactly 5 cycles after the start edge; `busy` high for 4 cycles.
- Sub 100 − 28 → `result` 72, `cout` 1. Sub 50 − 100 → `result` 32'hFFFFFFCE, `cout` 0.
- Add 32'hFFFFFFFF + 1 → `result` 0, `cout` 1. With `ADDSUB_OVF_EN`:
  - 32'h7FFFFFFF + 1 → 32'h80000000, `ovf` 1;
  - 200 − 55 → 145, `ovf` 0.
- `start` pulsed again in cycle 2 of RUN with different operands → ignored; first result returned. A `start` held in the DONE cycle → second op accepted; its `done` arrives 5 cycles later.
- Assert `rst` in cycle 2 of RUN → next cycle all outputs 0, state IDLE, no `done` pulse. A new `start` then completes normally.
